// File: rtl/sram_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sram_ctrl_if : request/response handshake bundle for sram_ctrl
// Revision     : 1.0
// ---------------------------------------------------------------------------
interface sram_ctrl_if #(
  parameter int m = 8,
  parameter int n = 1024
);
  localparam int aw = $clog2(n);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [aw-1:0] req_addr;
  logic [m-1:0]  req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [m-1:0]  rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sram_ctrl : zero-fills a single-port SRAM after reset, then serves
//             read/write requests with a registered read-response channel.
// Revision  : 1.0
// ---------------------------------------------------------------------------
module sram_ctrl #(
  parameter  int m  = 8,
  parameter  int n  = 1024,
  localparam int aw = $clog2(n)
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_ctrl_if.slave    bus,
  output logic          init_done,
  output logic          mem_we,
  output logic          mem_re,
  output logic [aw-1:0] mem_addr,
  output logic [m-1:0]  mem_din,
  input  logic [m-1:0]  mem_dout
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [aw-1:0] last_addr = aw'(n - 1);

  state_t        state;
  state_t        state_nx;
  logic [aw-1:0] ic;
  logic [aw-1:0] ic_nx;
  logic [aw-1:0] addr_q;
  logic [m-1:0]  din_q;
  logic          rsp_valid_q;
  logic [m-1:0]  rsp_rdata_q;
  logic          req_ready_w;
  logic          rd_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RST;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    ic_nx       = ic;
    req_ready_w = 1'b0;
    rd_acc      = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = addr_q;
    mem_din     = din_q;
    case (state)
      ST_RST: begin
        state_nx = ST_INIT;
      end
      ST_INIT: begin
        mem_we   = 1'b1;
        mem_addr = ic;
        mem_din  = '0;
        // Counter parks on the last address so non-power-of-two depths never wrap.
        if (ic == last_addr) begin
          state_nx = ST_RUN;
        end else begin
          ic_nx = ic + 1'b1;
        end
      end
      ST_RUN: begin
        req_ready_w = !rsp_valid_q || bus.rsp_ready;
        if (bus.req_valid && req_ready_w) begin
          mem_addr = bus.req_addr;
          if (bus.req_we) begin
            mem_we  = 1'b1;
            mem_din = bus.req_wdata;
          end else begin
            mem_re = 1'b1;
            rd_acc = 1'b1;
          end
        end
      end
      default: begin
        state_nx = ST_RST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic          <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      ic     <= ic_nx;
      addr_q <= mem_addr;
      din_q  <= mem_din;
      // A read accepted while the old response drains replaces it seamlessly.
      if (rd_acc) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= mem_dout;
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = req_ready_w;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign init_done     = (state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_sram_ctrl : table-driven bench with response scoreboard (n=16 and n=5).
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fill = 1'b1;
  always #5 clk = ~clk;

  sram_ctrl_if #(.m(8), .n(16)) bus16 ();
  sram_ctrl_if #(.m(8), .n(5))  bus5 ();

  logic       init_done16, mem_we16, mem_re16;
  logic [3:0] mem_addr16;
  logic [7:0] mem_din16, mem_dout16;
  logic       init_done5, mem_we5, mem_re5;
  logic [2:0] mem_addr5;
  logic [7:0] mem_din5, mem_dout5;

  logic [7:0] mem16 [16];
  logic [7:0] mem5  [8];

  sram_ctrl #(.m(8), .n(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16.slave), .init_done(init_done16),
    .mem_we(mem_we16), .mem_re(mem_re16), .mem_addr(mem_addr16),
    .mem_din(mem_din16), .mem_dout(mem_dout16)
  );

  sram_ctrl #(.m(8), .n(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5.slave), .init_done(init_done5),
    .mem_we(mem_we5), .mem_re(mem_re5), .mem_addr(mem_addr5),
    .mem_din(mem_din5), .mem_dout(mem_dout5)
  );

  // Attached memories: synchronous write, asynchronous read, prefilled with junk.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 16; i++) mem16[i] <= 8'hFF;
      for (int i = 0; i < 8; i++)  mem5[i]  <= 8'hEE;
    end else begin
      if (mem_we16) mem16[mem_addr16] <= mem_din16;
      if (mem_we5)  mem5[mem_addr5]   <= mem_din5;
    end
  end
  assign mem_dout16 = mem16[mem_addr16];
  assign mem_dout5  = mem5[mem_addr5];

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus16.rsp_valid && bus16.rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got 0x%0h expected no response at %0t", bus16.rsp_rdata, $time);
      end else begin
        chk("rsp_rdata", bus16.rsp_rdata, sb.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && mem_we5) chk("n5_addr_range", {31'd0, mem_addr5 > 3'd4}, 32'd0);
  end

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
    logic       exp_rv;
  } vec_t;

  task automatic check_reset();
    chk("rst_req_ready", bus16.req_ready, 0);
    chk("rst_rsp_valid", bus16.rsp_valid, 0);
    chk("rst_init_done", init_done16, 0);
    chk("rst_mem_we", mem_we16, 0);
    chk("rst_mem_re", mem_re16, 0);
    chk("rst_rsp_rdata", bus16.rsp_rdata, 0);
    chk("rst_mem_addr", mem_addr16, 0);
    chk("rst_mem_din", mem_din16, 0);
    chk("rst_n5_init_done", init_done5, 0);
    chk("rst_n5_mem_we", mem_we5, 0);
  endtask

  // Called just after reset release at a negedge; cycle c follows edge c.
  task automatic init_check(input int last_c);
    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk);
      #1;
      chk("init_mem_re", mem_re16, 0);
      if (c <= 16) begin
        chk("init_we", mem_we16, 1);
        chk("init_addr", mem_addr16, c - 1);
        chk("init_din", mem_din16, 0);
        chk("init_req_ready", bus16.req_ready, 0);
        chk("init_done_lo", init_done16, 0);
      end else begin
        chk("init_done_hi", init_done16, 1);
        chk("run_req_ready", bus16.req_ready, 1);
        chk("run_idle_we", mem_we16, 0);
      end
      if (c <= 5) begin
        chk("n5_init_we", mem_we5, 1);
        chk("n5_init_addr", mem_addr5, c - 1);
        chk("n5_init_done_lo", init_done5, 0);
      end else begin
        chk("n5_init_done_hi", init_done5, 1);
        chk("n5_idle_we", mem_we5, 0);
      end
    end
  endtask

  // Entered at posedge+1; leaves at the posedge+1 after the request is taken.
  task automatic apply(input vec_t v);
    bus16.req_valid = 1'b1;
    bus16.req_we    = v.we;
    bus16.req_addr  = v.addr;
    bus16.req_wdata = v.wdata;
    if (!v.we) sb.push_back(v.exp);
    @(negedge clk);
    chk("vec_req_ready", bus16.req_ready, 1);
    chk("vec_rsp_valid", bus16.rsp_valid, v.exp_rv);
    chk("vec_mem_we", mem_we16, v.we);
    chk("vec_mem_re", mem_re16, !v.we);
    chk("vec_mem_addr", mem_addr16, v.addr);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus16.req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain_rsp_valid", bus16.rsp_valid, 0);
    chk("drain_sb_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  vec_t tab_a [15];
  vec_t tab_b [4];

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tab_a = '{
      '{1'b0, 4'd9,  8'h00, 8'h00, 1'b0},
      '{1'b1, 4'd3,  8'hA5, 8'h00, 1'b1},
      '{1'b0, 4'd3,  8'h00, 8'hA5, 1'b0},
      '{1'b1, 4'd0,  8'h10, 8'h00, 1'b1},
      '{1'b1, 4'd1,  8'h11, 8'h00, 1'b0},
      '{1'b1, 4'd2,  8'h12, 8'h00, 1'b0},
      '{1'b1, 4'd3,  8'h13, 8'h00, 1'b0},
      '{1'b0, 4'd0,  8'h00, 8'h10, 1'b0},
      '{1'b0, 4'd1,  8'h00, 8'h11, 1'b1},
      '{1'b0, 4'd2,  8'h00, 8'h12, 1'b1},
      '{1'b0, 4'd3,  8'h00, 8'h13, 1'b1},
      '{1'b1, 4'd7,  8'h5C, 8'h00, 1'b1},
      '{1'b1, 4'd15, 8'hFF, 8'h00, 1'b0},
      '{1'b0, 4'd15, 8'h00, 8'hFF, 1'b0},
      '{1'b0, 4'd14, 8'h00, 8'h00, 1'b1}
    };
    tab_b = '{
      '{1'b0, 4'd3,  8'h00, 8'h00, 1'b0},
      '{1'b1, 4'd15, 8'h3C, 8'h00, 1'b1},
      '{1'b0, 4'd15, 8'h00, 8'h3C, 1'b0},
      '{1'b0, 4'd9,  8'h00, 8'h00, 1'b1}
    };
    bus16.req_valid = 1'b0;
    bus16.req_we    = 1'b0;
    bus16.req_addr  = '0;
    bus16.req_wdata = '0;
    bus16.rsp_ready = 1'b1;
    bus5.req_valid  = 1'b0;
    bus5.req_we     = 1'b0;
    bus5.req_addr   = '0;
    bus5.req_wdata  = '0;
    bus5.rsp_ready  = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    fill  = 1'b0;
    rst_n = 1'b1;
    init_check(18);
    for (int i = 0; i < 5; i++) chk("n5_filled", mem5[i], 0);
    for (int i = 5; i < 8; i++) chk("n5_untouched", mem5[i], 8'hEE);

    for (int i = 0; i < 15; i++) apply(tab_a[i]);
    drain();

    // Backpressure: response held, a pending write must not reach the SRAM.
    bus16.rsp_ready = 1'b0;
    bus16.req_valid = 1'b1;
    bus16.req_we    = 1'b0;
    bus16.req_addr  = 4'd7;
    sb.push_back(8'h5C);
    @(posedge clk);
    #1;
    bus16.req_we    = 1'b1;
    bus16.req_addr  = 4'd0;
    bus16.req_wdata = 8'h77;
    repeat (3) begin
      @(negedge clk);
      chk("bp_rsp_valid", bus16.rsp_valid, 1);
      chk("bp_rsp_rdata", bus16.rsp_rdata, 8'h5C);
      chk("bp_req_ready", bus16.req_ready, 0);
      chk("bp_mem_we", mem_we16, 0);
      chk("bp_mem_re", mem_re16, 0);
      @(posedge clk);
      #1;
    end
    bus16.req_valid = 1'b0;
    bus16.rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_single_rsp", bus16.rsp_valid, 0);
    @(posedge clk);
    #1;
    apply('{1'b0, 4'd0, 8'h00, 8'h10, 1'b0});
    drain();

    // Reset while a response is pending: it must never be presented.
    bus16.rsp_ready = 1'b0;
    bus16.req_valid = 1'b1;
    bus16.req_we    = 1'b0;
    bus16.req_addr  = 4'd1;
    @(posedge clk);
    #1;
    bus16.req_valid = 1'b0;
    @(negedge clk);
    chk("pend_rsp_valid", bus16.rsp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();
    bus16.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    init_check(8);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    init_check(18);

    for (int i = 0; i < 4; i++) apply(tab_b[i]);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_ctrl.md
# sram_ctrl

Request-side controller for the single-port `sram_seq` memory (synchronous write, asynchronous read). It accepts read and write requests over a valid/ready handshake and drives the SRAM's `we`/`re`/`addr`/`data_in` pins. It registers read data into a response channel that has its own valid/ready handshake. After every reset it zero-fills the whole array before accepting any request, so downstream logic never sees uninitialised contents.

## Interface
Parameters:
- `m`, default 8: data width in bits; must match the attached SRAM.
- `n`, default 1024: depth in words; any value ≥ 2, not required to be a power of two. Address width `aw = $clog2(n)`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request this cycle.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  aw  request address.
- `req_wdata`  in  m  write data.
- `rsp_valid`  out  1  read data valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  m  read data.
- `init_done`  out  1  zero-fill complete; stays high until the next reset.
- `mem_we`  out  1  to SRAM `we`.
- `mem_re`  out  1  to SRAM `re`.
- `mem_addr`  out  aw  to SRAM `addr`.
- `mem_din`  out  m  to SRAM `data_in`.
- `mem_dout`  in  m  from SRAM `data_out`; combinational in `mem_addr`.

## Operation
- States:
  - RST: entered asynchronously while `rst_n` is low.
  - INIT: zero-fill.
  - RUN: normal operation.
- Transitions:
  - RST → INIT on the first edge after `rst_n` rises.
  - INIT → RUN on the edge that writes address n-1.
  - RUN has no exit except reset.
- INIT behaviour:
  - Counter `ic` (aw bits) starts at 0.
  - Each cycle drives `mem_we`=1, `mem_addr`=`ic`, `mem_din`=0, then `ic` increments.
  - `ic` stops at n-1 and does not wrap, including for non-power-of-two n.
  - `req_ready`=0 throughout INIT.
- `req_ready` = RUN && (!`rsp_valid` || `rsp_ready`).
- Accept condition: `acc` = `req_valid` && `req_ready`.
- Write path (RUN, `acc` && `req_we`):
  - Combinationally drive `mem_we`=1, `mem_addr`=`req_addr`, `mem_din`=`req_wdata`.
  - The SRAM captures the word at that edge.
  - No response is generated.
- Read path (RUN, `acc` && !`req_we`):
  - Combinationally drive `mem_re`=1, `mem_addr`=`req_addr`.
  - `mem_dout` is registered into `rsp_rdata` and `rsp_valid` is set at that edge.
- Response channel:
  - The response is held stable while `rsp_valid` && !`rsp_ready`.
  - It clears when `rsp_ready`=1, unless a new read is accepted in the same cycle; in that case `rsp_valid` stays 1 and `rsp_rdata` takes the new word.
- Idle outputs:
  - `mem_we`=`mem_re`=0 whenever no write/read is being issued.
  - `mem_addr`/`mem_din` hold their last driven value (don't-care to the SRAM when `we`/`re` are low).
- Reset mid-operation: any in-flight response is discarded, all outputs return to their reset values, and INIT restarts from address 0.

## Timing
- Reset values (while `rst_n`=0):
  - `req_ready`=0, `rsp_valid`=0, `init_done`=0, `mem_we`=0, `mem_re`=0.
  - `rsp_rdata`=0, `mem_addr`=0, `mem_din`=0.
- Initialisation timing:
  - INIT occupies exactly n cycles, starting the first cycle after reset release.
  - `init_done` and `req_ready` rise on cycle n+1 after release.
- Read latency: 1 cycle. A read accepted at edge k gives `rsp_valid`=1 with data after edge k.
- Throughput: one request per cycle while `rsp_ready` is held high, including back-to-back reads.
- Write then read of the same address on consecutive cycles returns the new data; the write completes at the edge before the read's combinational access.
- Backpressure: with `rsp_valid`=1 and `rsp_ready`=0, `req_ready`=0, and no SRAM access of any kind is issued.

## Test plan
- Reset release with n=16: `mem_we`=1 for 16 cycles on addresses 0..15 with `mem_din`=0, then `init_done`=1 on cycle 17; a read of address 9 returns 0x00.
- Write 0xA5 to address 3, then read address 3 on the next cycle: `rsp_valid`=1 one cycle after the read is accepted, with `rsp_rdata`=0xA5.
- Four back-to-back reads of addresses 0..3 (preloaded 0x10..0x13) with `rsp_ready`=1: four consecutive response cycles carrying 0x10, 0x11, 0x12, 0x13 with no bubbles.
- Hold `rsp_ready`=0 for 3 cycles after a read of 0x5C: `rsp_rdata` is held at 0x5C, `req_ready`=0, and `mem_we`=`mem_re`=0; release gives one response only.
- Pulse `rst_n` low mid-INIT (at ic=7) and again with `rsp_valid`=1: outputs return to reset values immediately, INIT restarts at address 0, and the pending response is never presented.
- n=5 (non-power-of-two): INIT writes addresses 0..4 only, never address 5..7, and `init_done` rises on cycle 6.
